instruction_prefetch: RTL and testbench
=======================================

Name: instruction_prefetch

Overview:
- Upstream neighbour of the control unit: fetches 16-bit instructions from instruction memory and buffers them in a small queue.
- Presents the queue head as instruction_out (feeds control's instruction_in); control's ir_wr pulse pops it.
- Memory side uses a req/ack command handshake and a separate valid data-return strobe with variable latency; at most one request is outstanding.
- Branches redirect the fetch pointer and flush the queue.

Parameters:
- ADDRESS_WIDTH, 11, instruction address width; matches control DATA_WIDTH.
- INSTRUCTION_WIDTH, 16, instruction word width.
- DEPTH, 2, queue entries; power of two, at least 2.

Ports:
- clock_in  input  1  single clock; all state changes on the rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- redirect_in  input  1  one-cycle pulse: flush the queue and load the fetch pointer.
- redirect_address_in  input  ADDRESS_WIDTH  new fetch address, sampled when redirect_in=1.
- imem_req_out  output  1  fetch request.
- imem_address_out  output  ADDRESS_WIDTH  fetch address; always equals the fetch pointer.
- imem_ack_in  input  1  request accepted this cycle (qualified by imem_req_out).
- imem_valid_in  input  1  read data returning this cycle.
- imem_data_in  input  INSTRUCTION_WIDTH  returned instruction word.
- instruction_out  output  INSTRUCTION_WIDTH  queue-head instruction; 0 when the queue is empty.
- instruction_pc_out  output  ADDRESS_WIDTH  address of the head instruction; 0 when empty.
- instruction_valid_out  output  1  queue not empty.
- instruction_take_in  input  1  pop the head (driven by control ir_wr).
- queue_count_out  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset_in=0, asynchronous):
  - fetch pointer = 0, queue empty, FSM = IDLE.
  - All outputs go to 0 immediately.
  - Any outstanding response is forgotten; an imem_valid_in arriving after reset release in IDLE is ignored.
- FSM states: IDLE, WAIT, DROP (encoding in package).
- IDLE:
  - imem_req_out = (count < DEPTH) && !redirect_in.
  - On req && ack: fetch pointer <= pointer+1, wrapping modulo 2^ADDRESS_WIDTH (0x7FF -> 0x000); go to WAIT.
  - On req without ack: hold the address and keep req asserted; the pointer does not change.
  - imem_valid_in is ignored in IDLE.
- WAIT:
  - imem_req_out = 0.
  - On imem_valid_in: push {imem_data_in, address of the request} into the queue and go to IDLE.
  - Memory guarantees valid no earlier than the cycle after ack.
  - No overflow is possible: count < DEPTH at issue, and only pops occur while waiting.
- DROP:
  - imem_req_out = 0.
  - On imem_valid_in: discard the data and go to IDLE.
- Redirect (highest priority, any state):
  - Queue is flushed (count=0 next cycle) and fetch pointer <= redirect_address_in.
  - imem_req_out is forced to 0 in the redirect cycle.
  - instruction_take_in is ignored in the redirect cycle.
  - Next state: IDLE->IDLE; WAIT with valid in the same cycle -> IDLE, data discarded; WAIT without valid -> DROP; DROP with valid -> IDLE; DROP without valid -> DROP.
- Queue:
  - Circular buffer with rd/wr pointers and a count.
  - Simultaneous push and take: both occur, count unchanged.
  - Take while empty is ignored.
  - Push into an empty queue: instruction_valid_out rises the next cycle.
  - Outputs are registered-state driven; no combinational path from imem_data_in to instruction_out.
- Latency and throughput:
  - Earliest request: first clock after reset release.
  - Ack in cycle N, valid in N+1 -> instruction visible in N+2.
  - Maximum throughput: one instruction per 2 cycles (IDLE/WAIT alternation).

Decomposition:
- Package prefetch_pkg: prefetch_state_t enum {IDLE, WAIT, DROP} and a queue entry struct {instruction, pc}.
- Sub-module prefetch_queue: parameterised circular buffer (push, pop, flush, count, head), instantiated once.
- FSM, fetch pointer and handshake logic stay in instruction_prefetch.

Test Plan:
- Reset release, memory acks immediately, data returns 1 cycle later as 0x1000+address, take=0 -> requests at addresses 0 and 1; queue_count=2; req stays 0; head=0x1000, pc=0.
- With the queue full, pulse take every cycle -> head sequence 0x1000, 0x1001, 0x1002...; count never exceeds 2; a take in the same cycle as a push leaves count unchanged.
- Ack held low 3 cycles -> imem_address_out stable at 0x002 with req high; pointer increments only on the ack cycle.
- Redirect to 0x7FF while in WAIT; the stale response returns 0xDEAD 2 cycles later -> 0xDEAD never enters the queue; next requests are 0x7FF then 0x000 (wrap); instruction_pc_out=0x7FF on first valid.
- Redirect in the same cycle as imem_valid_in in WAIT -> data discarded; state IDLE; req to the redirect address on the next cycle.
- Assert reset_in=0 mid-WAIT with 1 entry queued -> all outputs 0 before the next clock edge; the late imem_valid_in after release is ignored; fetching restarts at 0x000.

Source files
------------

// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetcher: FSM state encoding and the
// queue entry layout at the default widths.
package prefetch_pkg;

    localparam int PF_ADDRESS_WIDTH     = 11;
    localparam int PF_INSTRUCTION_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } prefetch_state_t;

    typedef struct packed {
        logic [PF_INSTRUCTION_WIDTH-1:0] instruction;
        logic [PF_ADDRESS_WIDTH-1:0]     pc;
    } prefetch_entry_t;

endpackage

// File: rtl/prefetch_queue.sv
// Circular buffer of fetched entries with flush; the head reads as zero when
// the buffer is empty so downstream never sees stale words.
module prefetch_queue #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: reads are masked by the count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = (count_q == '0) ? '0 : mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/instruction_prefetch.sv
// Fetches instructions from memory one request at a time and buffers them
// for the control unit; redirects flush the buffer and reload the pointer.
module instruction_prefetch
    import prefetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = PF_ADDRESS_WIDTH,
    parameter int INSTRUCTION_WIDTH = PF_INSTRUCTION_WIDTH,
    parameter int DEPTH             = 2,
    localparam int CW               = $clog2(DEPTH) + 1
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         redirect_in,
    input  logic [ADDRESS_WIDTH-1:0]     redirect_address_in,
    output logic                         imem_req_out,
    output logic [ADDRESS_WIDTH-1:0]     imem_address_out,
    input  logic                         imem_ack_in,
    input  logic                         imem_valid_in,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_data_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [ADDRESS_WIDTH-1:0]     instruction_pc_out,
    output logic                         instruction_valid_out,
    input  logic                         instruction_take_in,
    output logic [CW-1:0]                queue_count_out,
    output prefetch_state_t              state_out
);

    localparam int EW = INSTRUCTION_WIDTH + ADDRESS_WIDTH;

    // Handshake: a request transfers on the cycle where imem_req_out and
    // imem_ack_in are both high; imem_valid_in is a one-cycle data strobe
    // that arrives no earlier than the cycle after the accepting ack.
    prefetch_state_t            state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   fetch_ptr;
    logic [ADDRESS_WIDTH-1:0]   req_pc;
    logic                       push;
    logic                       pop;
    logic [EW-1:0]              head;

    always_comb begin
        state_d      = state_q;
        imem_req_out = 1'b0;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                // Reset gating keeps the request quiet while reset is held.
                imem_req_out = (queue_count_out < CW'(DEPTH)) && !redirect_in && reset_in;
                if (imem_req_out && imem_ack_in) state_d = WAIT;
            end
            WAIT: begin
                if (imem_valid_in) begin
                    push    = !redirect_in;
                    state_d = IDLE;
                end else if (redirect_in) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_valid_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= IDLE;
            fetch_ptr <= '0;
            req_pc    <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_in) begin
                fetch_ptr <= redirect_address_in;
            end else if (imem_req_out && imem_ack_in) begin
                fetch_ptr <= fetch_ptr + 1'b1;
                req_pc    <= fetch_ptr;
            end
        end
    end

    assign pop = instruction_take_in && !redirect_in;

    prefetch_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clock_in),
        .rst_n     (reset_in),
        .flush     (redirect_in),
        .push      (push),
        .push_data ({imem_data_in, req_pc}),
        .pop       (pop),
        .head      (head),
        .count     (queue_count_out)
    );

    assign imem_address_out      = fetch_ptr;
    assign instruction_out       = head[EW-1:ADDRESS_WIDTH];
    assign instruction_pc_out    = head[ADDRESS_WIDTH-1:0];
    assign instruction_valid_out = (queue_count_out != '0);
    assign state_out             = state_q;

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch: a scripted memory responder pushes
// expected {instruction, pc} entries that are checked as the head is taken.
module tb_instruction_prefetch;
    import prefetch_pkg::*;

    localparam int AW = 11;
    localparam int IW = 16;
    localparam int EW = AW + IW;

    logic          clk;
    logic          reset_in;
    logic          redirect_in;
    logic [AW-1:0] redirect_address_in;
    logic          imem_req_out;
    logic [AW-1:0] imem_address_out;
    logic          imem_ack_in;
    logic          imem_valid_in;
    logic [IW-1:0] imem_data_in;
    logic [IW-1:0] instruction_out;
    logic [AW-1:0] instruction_pc_out;
    logic          instruction_valid_out;
    logic          instruction_take_in;
    logic [1:0]    queue_count_out;
    prefetch_state_t state_out;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    instruction_prefetch dut (
        .clock_in              (clk),
        .reset_in              (reset_in),
        .redirect_in           (redirect_in),
        .redirect_address_in   (redirect_address_in),
        .imem_req_out          (imem_req_out),
        .imem_address_out      (imem_address_out),
        .imem_ack_in           (imem_ack_in),
        .imem_valid_in         (imem_valid_in),
        .imem_data_in          (imem_data_in),
        .instruction_out       (instruction_out),
        .instruction_pc_out    (instruction_pc_out),
        .instruction_valid_out (instruction_valid_out),
        .instruction_take_in   (instruction_take_in),
        .queue_count_out       (queue_count_out),
        .state_out             (state_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] addr);
        return 16'h1000 + IW'(addr);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},   32'(imem_req_out), 32'(0));
        chk({tag, "_addr"},  32'(imem_address_out), 32'(0));
        chk({tag, "_instr"}, 32'(instruction_out), 32'(0));
        chk({tag, "_pc"},    32'(instruction_pc_out), 32'(0));
        chk({tag, "_valid"}, 32'(instruction_valid_out), 32'(0));
        chk({tag, "_count"}, 32'(queue_count_out), 32'(0));
        chk({tag, "_state"}, 32'(state_out), 32'(IDLE));
    endtask

    // Compares the current head against the scoreboard front and pops it.
    // Caller must have driven instruction_take_in for this cycle.
    task automatic check_head_pop(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed take with empty expected queue, required entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(instruction_valid_out), 32'(1));
            chk({tag, "_instr"}, 32'(instruction_out), 32'(e[EW-1:AW]));
            chk({tag, "_pc"},    32'(instruction_pc_out), 32'(e[AW-1:0]));
        end
    endtask

    task automatic take_one(input string tag);
        instruction_take_in = 1'b1;
        #1;
        check_head_pop(tag);
        cyc();
        instruction_take_in = 1'b0;
    endtask

    // Memory driver: stall the ack, accept, return mem_word(addr) next cycle.
    task automatic fetch(input logic [AW-1:0] addr, input int stall, input logic take_on_valid,
                         input string tag);
        imem_ack_in = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            chk({tag, "_stall_req"},  32'(imem_req_out), 32'(1));
            chk({tag, "_stall_addr"}, 32'(imem_address_out), 32'(addr));
            cyc();
        end
        imem_ack_in = 1'b1;
        #1;
        chk({tag, "_req"},  32'(imem_req_out), 32'(1));
        chk({tag, "_addr"}, 32'(imem_address_out), 32'(addr));
        cyc();
        imem_ack_in   = 1'b0;
        imem_valid_in = 1'b1;
        imem_data_in  = mem_word(addr);
        instruction_take_in = take_on_valid;
        #1;
        chk({tag, "_wait_req"},   32'(imem_req_out), 32'(0));
        chk({tag, "_wait_state"}, 32'(state_out), 32'(WAIT));
        if (take_on_valid) check_head_pop({tag, "_take"});
        cyc();
        exp_q.push_back({mem_word(addr), addr});
        imem_valid_in       = 1'b0;
        instruction_take_in = 1'b0;
    endtask

    initial begin
        reset_in            = 1'b0;
        redirect_in         = 1'b0;
        redirect_address_in = '0;
        imem_ack_in         = 1'b0;
        imem_valid_in       = 1'b0;
        imem_data_in        = '0;
        instruction_take_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Fill the queue from address 0
        reset_in = 1'b1;
        fetch(11'h000, 0, 1'b0, "fill0");
        #1;
        chk("fill0_count", 32'(queue_count_out), 32'(1));
        fetch(11'h001, 0, 1'b0, "fill1");
        #1;
        chk("full_count", 32'(queue_count_out), 32'(2));
        chk("full_req",   32'(imem_req_out), 32'(0));
        chk("full_head",  32'(instruction_out), 32'(16'h1000));
        chk("full_pc",    32'(instruction_pc_out), 32'(0));
        cyc();
        chk("full_req_hold", 32'(imem_req_out), 32'(0));

        // Take while full, then a stalled fetch with take colliding with push
        instruction_take_in = 1'b1;
        #1;
        chk("take_full_req", 32'(imem_req_out), 32'(0));
        check_head_pop("take0");
        cyc();
        instruction_take_in = 1'b0;
        #1;
        chk("after_take_count", 32'(queue_count_out), 32'(1));
        fetch(11'h002, 3, 1'b1, "stall2");
        #1;
        chk("push_take_count", 32'(queue_count_out), 32'(1));
        take_one("take2");
        chk("drained_count", 32'(queue_count_out), 32'(0));
        chk("drained_valid", 32'(instruction_valid_out), 32'(0));
        chk("drained_instr", 32'(instruction_out), 32'(0));
        chk("drained_pc",    32'(instruction_pc_out), 32'(0));

        // Redirect to 0x7FF while waiting; stale 0xDEAD must be dropped
        imem_ack_in = 1'b1;
        #1;
        chk("rd_issue_addr", 32'(imem_address_out), 32'(3));
        cyc();
        imem_ack_in         = 1'b0;
        redirect_in         = 1'b1;
        redirect_address_in = 11'h7FF;
        #1;
        chk("rd_req_forced", 32'(imem_req_out), 32'(0));
        cyc();
        redirect_in = 1'b0;
        #1;
        chk("rd_state_drop", 32'(state_out), 32'(DROP));
        chk("rd_drop_req",   32'(imem_req_out), 32'(0));
        chk("rd_ptr",        32'(imem_address_out), 32'(11'h7FF));
        cyc();
        imem_valid_in = 1'b1;
        imem_data_in  = 16'hDEAD;
        cyc();
        imem_valid_in = 1'b0;
        #1;
        chk("stale_count", 32'(queue_count_out), 32'(0));
        chk("stale_state", 32'(state_out), 32'(IDLE));
        fetch(11'h7FF, 0, 1'b0, "wrap_hi");
        #1;
        chk("wrap_pc_first", 32'(instruction_pc_out), 32'(11'h7FF));
        fetch(11'h000, 0, 1'b0, "wrap_lo");
        take_one("take_7ff");
        take_one("take_000");

        // Redirect coinciding with valid in WAIT
        imem_ack_in = 1'b1;
        #1;
        chk("rv_issue_addr", 32'(imem_address_out), 32'(1));
        cyc();
        imem_ack_in         = 1'b0;
        imem_valid_in       = 1'b1;
        imem_data_in        = 16'hBEEF;
        redirect_in         = 1'b1;
        redirect_address_in = 11'h123;
        cyc();
        imem_valid_in = 1'b0;
        redirect_in   = 1'b0;
        #1;
        chk("rv_state", 32'(state_out), 32'(IDLE));
        chk("rv_count", 32'(queue_count_out), 32'(0));
        fetch(11'h123, 0, 1'b0, "rv_fetch");
        #1;
        chk("rv_count1", 32'(queue_count_out), 32'(1));

        // Asynchronous reset mid-WAIT with one entry queued
        imem_ack_in = 1'b1;
        #1;
        chk("mr_issue_addr", 32'(imem_address_out), 32'(11'h124));
        cyc();
        imem_ack_in = 1'b0;
        #1;
        reset_in = 1'b0;
        #1;
        check_all_zero("midreset");
        cyc();
        exp_q.delete();
        reset_in      = 1'b1;
        imem_valid_in = 1'b1;
        imem_data_in  = 16'hBAD0;
        #1;
        chk("late_req",  32'(imem_req_out), 32'(1));
        chk("late_addr", 32'(imem_address_out), 32'(0));
        cyc();
        imem_valid_in = 1'b0;
        #1;
        chk("late_count", 32'(queue_count_out), 32'(0));
        fetch(11'h000, 0, 1'b0, "restart");
        take_one("take_restart");
        chk("end_count", 32'(queue_count_out), 32'(0));
        chk("end_sb_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
